// File: rtl/mux_32_1_if.sv
// Read-port slice bus: 32 data bits and a 5-bit register select in, one selected bit out.
interface mux_32_1_if;
    logic [31:0] in;
    logic [4:0]  sel;
    logic        out;

    modport master (output in, output sel, input out);
    modport slave  (input in, input sel, output out);
endinterface

// File: rtl/mux_32_1.sv
// Single-bit 32:1 read-port mux built as a not/and/or gate tree so read-path delay shows up
// in simulation; sel=k returns in[31-k]. Optional output flop with async active-high reset.
module mux_32_1_m4 #(
    parameter int DELAY = 50
) (
    input  wire [3:0] d,
    input  wire [1:0] s,
    input  wire [1:0] sn,
    output wire       y
);
    wire [3:0] t;

    // Each AND takes the raw/inverted select bits directly, keeping decode out of the data path.
    and #(DELAY) a0 (t[0], d[0], sn[1], sn[0]);
    and #(DELAY) a1 (t[1], d[1], sn[1], s[0]);
    and #(DELAY) a2 (t[2], d[2], s[1],  sn[0]);
    and #(DELAY) a3 (t[3], d[3], s[1],  s[0]);
    or  #(DELAY) o0 (y, t[0], t[1], t[2], t[3]);
endmodule

module mux_32_1 #(
    parameter int DELAY      = 50,
    parameter bit REGISTERED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    mux_32_1_if.slave   bus
);
    // v[k] is register k's bit: the parent packs register 0 into in[31].
    wire [0:31] v;
    wire [4:0]  sn;
    wire [7:0]  l1;
    wire [1:0]  l2;
    wire [1:0]  t;
    wire        tree;
    logic       out_d, out_q;

    assign v = bus.in;

    for (genvar i = 0; i < 5; i++) begin : g_inv
        not #(DELAY) n (sn[i], bus.sel[i]);
    end

    for (genvar g = 0; g < 8; g++) begin : g_l1
        mux_32_1_m4 #(.DELAY(DELAY)) u_m4 (
            .d  ({v[4*g+3], v[4*g+2], v[4*g+1], v[4*g]}),
            .s  (bus.sel[1:0]),
            .sn (sn[1:0]),
            .y  (l1[g])
        );
    end

    for (genvar h = 0; h < 2; h++) begin : g_l2
        mux_32_1_m4 #(.DELAY(DELAY)) u_m4 (
            .d  (l1[4*h+3:4*h]),
            .s  (bus.sel[3:2]),
            .sn (sn[3:2]),
            .y  (l2[h])
        );
    end

    and #(DELAY) f0 (t[0], l2[0], sn[4]);
    and #(DELAY) f1 (t[1], l2[1], bus.sel[4]);
    or  #(DELAY) f2 (tree, t[0], t[1]);

    assign out_d = tree;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) out_q <= 1'b0;
        else       out_q <= out_d;
    end

    // The flop is dead logic when REGISTERED=0; clk/reset then have no effect on out.
    assign bus.out = REGISTERED ? out_q : tree;
endmodule

// File: tb/tb_mux_32_1.sv
// Bench for mux_32_1: combinational and registered instances plus a 64-wide read port.
module tb_mux_32_1;
    localparam int DELAY  = 50;
    localparam int SETTLE = 500;

    logic clk, rst;
    int   n_chk = 0, n_pass = 0;
    logic [63:0] exp_q[$];

    mux_32_1_if ifc0 ();
    mux_32_1_if ifc1 ();

    mux_32_1 #(.DELAY(DELAY), .REGISTERED(1'b0)) u_comb (.clk(clk), .reset(rst), .bus(ifc0.slave));
    mux_32_1 #(.DELAY(DELAY), .REGISTERED(1'b1)) u_reg  (.clk(clk), .reset(rst), .bus(ifc1.slave));

    // 64-bit read port: one slice per data bit, shared select.
    logic [63:0][31:0] m64_in;
    logic [4:0]        m64_sel;
    logic [63:0]       m64_out;

    for (genvar b = 0; b < 64; b++) begin : g64
        mux_32_1_if bi ();
        mux_32_1 #(.DELAY(DELAY), .REGISTERED(1'b0)) u (.clk(clk), .reset(rst), .bus(bi.slave));
        assign bi.in      = m64_in[b];
        assign bi.sel     = m64_sel;
        assign m64_out[b] = bi.out;
    end

    initial begin
        clk = 1'b0;
        forever #500 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input logic [63:0] e);
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input string tag, input logic [63:0] obs);
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL %s: got %h expected <scoreboard empty>", tag, obs);
        end else begin
            chk(tag, obs, exp_q.pop_front());
        end
    endtask

    task automatic drive0(input logic [31:0] in, input logic [4:0] sel);
        ifc0.in  = in;
        ifc0.sel = sel;
        push({63'd0, in[31 - int'(sel)]});
    endtask

    initial begin
        logic [31:0] rin;
        logic [4:0]  rsel;

        rst      = 1'b1;
        ifc1.in  = 32'hFFFF_FFFF;
        ifc1.sel = 5'd7;
        ifc0.in  = 32'd0;
        ifc0.sel = 5'd0;
        m64_in   = '0;
        m64_sel  = 5'd0;

        // Registered instance: reset, release, async re-assert, latency.
        #100;  push(64'd0); pop_chk("reg_rst", {63'd0, ifc1.out});
        @(posedge clk); #1; push(64'd0); pop_chk("reg_rst_edge", {63'd0, ifc1.out});
        #100;  rst = 1'b0;
        #1;    push(64'd0); pop_chk("reg_pre_edge", {63'd0, ifc1.out});
        @(posedge clk); #1; push(64'd1); pop_chk("reg_load", {63'd0, ifc1.out});
        #200;  rst = 1'b1;
        #1;    push(64'd0); pop_chk("reg_async", {63'd0, ifc1.out});
        #100;  rst = 1'b0;
        #1;    push(64'd0); pop_chk("reg_hold", {63'd0, ifc1.out});
        @(posedge clk); #1; push(64'd1); pop_chk("reg_reload", {63'd0, ifc1.out});
        ifc1.in = 32'h0000_0001; ifc1.sel = 5'd0;
        #SETTLE; push(64'd1); pop_chk("reg_latency_old", {63'd0, ifc1.out});
        @(posedge clk); #1; push(64'd0); pop_chk("reg_latency_new", {63'd0, ifc1.out});

        // Walking select over a single set bit.
        for (int k = 0; k < 32; k++) begin
            drive0(32'h0000_0001, 5'(k));
            #SETTLE; pop_chk($sformatf("walk_sel%0d", k), {63'd0, ifc0.out});
        end

        // Register k holds value k on the 64-bit port.
        for (int k = 0; k < 32; k++)
            for (int b = 0; b < 64; b++)
                m64_in[b][31-k] = (64'(k) >> b) & 64'd1;
        for (int k = 0; k < 32; k++) begin
            m64_sel = 5'(k);
            push(64'(k));
            #SETTLE; pop_chk($sformatf("m64_reg%0d", k), m64_out);
        end

        // Isolation: only in[21] matters at sel=10, even with X elsewhere.
        ifc0.sel = 5'd10;
        ifc0.in = 32'h0020_0000;
        push(64'd1); #SETTLE; pop_chk("iso_base", {63'd0, ifc0.out});
        for (int r = 0; r < 4; r++) begin
            rin = $urandom; rin[21] = 1'b1; ifc0.in = rin;
            push(64'd1); #SETTLE; pop_chk($sformatf("iso_rand%0d", r), {63'd0, ifc0.out});
        end
        ifc0.in = 'x; ifc0.in[21] = 1'b1;
        push(64'd1); #SETTLE; pop_chk("iso_x", {63'd0, ifc0.out});
        ifc0.in[21] = 1'b0;
        push(64'd0); #SETTLE; pop_chk("iso_clear", {63'd0, ifc0.out});

        // Settle bound: sel 1->0 with only in[31] set.
        drive0(32'h8000_0000, 5'd1);
        #SETTLE; pop_chk("tim_pre", {63'd0, ifc0.out});
        ifc0.sel = 5'd0;
        #(8*DELAY); push(64'd1); pop_chk("tim_bound", {63'd0, ifc0.out});
        for (int r = 0; r < 3; r++) begin
            #(DELAY); push(64'd1); pop_chk($sformatf("tim_hold%0d", r), {63'd0, ifc0.out});
        end

        // Random (in, sel) pairs.
        for (int r = 0; r < 2000; r++) begin
            rin  = $urandom;
            rsel = 5'($urandom_range(31, 0));
            drive0(rin, rsel);
            #SETTLE; pop_chk($sformatf("rand%0d", r), {63'd0, ifc0.out});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
